// File: rtl/layer_seq_pkg.sv
// Shared types for the layer sequencer: FSM state encoding and the queued command layout.
package layer_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_LAUNCH = 2'd1,
    SEQ_RUN    = 2'd2,
    SEQ_ERR    = 2'd3
  } seq_state_e;

  localparam int SEQ_CMD_W = 4;

  // Stored in the FIFO as {mode, relu_en, last}.
  typedef struct packed {
    logic [1:0] mode;
    logic       relu_en;
    logic       last;
  } seq_cmd_t;

  function automatic logic [SEQ_CMD_W-1:0] pack_cmd(input logic [1:0] mode,
                                                    input logic       relu_en,
                                                    input logic       last);
    seq_cmd_t c;
    c.mode    = mode;
    c.relu_en = relu_en;
    c.last    = last;
    return c;
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// Synchronous FIFO with occupancy counter; DEPTH must be a power of two so pointers wrap naturally.
module seq_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/layer_seq.sv
// Layer sequencer: queues per-layer commands, launches them one at a time into the accelerator,
// counts completed layers and latches a sticky error if a layer never finishes.
module layer_seq
  import layer_seq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT_W = 20,
  parameter int CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_mode,
  input  logic             i_cmd_relu_en,
  input  logic             i_cmd_last,
  output logic [1:0]       o_mode,
  output logic             o_relu_en,
  output logic             o_start,
  input  logic             i_finish,
  output logic             o_busy,
  output logic             o_layer_done,
  output logic             o_prog_done,
  output logic [CNT_W-1:0] o_layer_cnt,
  output logic             o_timeout
);

  // Command handshake: a command transfers on any cycle with i_cmd_valid & o_cmd_ready.
  // o_cmd_ready depends only on registered FIFO occupancy and FSM state.

  seq_state_e           state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic                 relu_q, relu_d;
  logic                 last_q, last_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 layer_done_q, layer_done_d;
  logic                 prog_done_q, prog_done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 restart_q, restart_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SEQ_CMD_W-1:0] fifo_rdata;
  seq_cmd_t             head;

  assign o_cmd_ready = ~fifo_full & (state_q != SEQ_ERR);
  assign fifo_push   = i_cmd_valid & o_cmd_ready;
  assign fifo_pop    = (state_q == SEQ_IDLE) & ~fifo_empty;
  assign head        = seq_cmd_t'(fifo_rdata);

  seq_fifo #(
    .WIDTH (SEQ_CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (fifo_push),
    .wdata   (pack_cmd(i_cmd_mode, i_cmd_relu_en, i_cmd_last)),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    relu_d       = relu_q;
    last_d       = last_q;
    start_d      = 1'b0;
    busy_d       = 1'b0;
    layer_done_d = 1'b0;
    prog_done_d  = 1'b0;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    wd_d         = wd_q;
    restart_d    = restart_q;
    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty) begin
          mode_d  = head.mode;
          relu_d  = head.relu_en;
          last_d  = head.last;
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = SEQ_LAUNCH;
        end
      end
      SEQ_LAUNCH: begin
        wd_d    = '0;
        busy_d  = 1'b1;
        state_d = SEQ_RUN;
        // First launch after a completed program starts a fresh count.
        if (restart_q) begin
          cnt_d     = '0;
          restart_d = 1'b0;
        end
      end
      SEQ_RUN: begin
        wd_d = wd_q + 1'b1;
        if (i_finish) begin
          layer_done_d = 1'b1;
          prog_done_d  = last_q;
          restart_d    = last_q;
          cnt_d        = cnt_q + 1'b1;
          state_d      = SEQ_IDLE;
        end else if (&wd_q) begin
          timeout_d = 1'b1;
          state_d   = SEQ_ERR;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = SEQ_ERR;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= SEQ_IDLE;
      mode_q       <= '0;
      relu_q       <= 1'b0;
      last_q       <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      prog_done_q  <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      wd_q         <= '0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      relu_q       <= relu_d;
      last_q       <= last_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
      prog_done_q  <= prog_done_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      wd_q         <= wd_d;
      restart_q    <= restart_d;
    end
  end

  assign o_mode       = mode_q;
  assign o_relu_en    = relu_q;
  assign o_start      = start_q;
  assign o_busy       = busy_q;
  assign o_layer_done = layer_done_q;
  assign o_prog_done  = prog_done_q;
  assign o_layer_cnt  = cnt_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_layer_seq.sv
// Bench for layer_seq: directed reset/launch/back-pressure/watchdog steps, then a randomized
// program checked against a schedule model computed from the launch/finish timing rules.
module tb_layer_seq;

  localparam int DEPTH     = 4;
  localparam int TIMEOUT_W = 4;
  localparam int CNT_W     = 8;
  localparam int N         = 24;
  localparam int MAXC      = 2000;

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [1:0]       i_cmd_mode;
  logic             i_cmd_relu_en;
  logic             i_cmd_last;
  logic [1:0]       o_mode;
  logic             o_relu_en;
  logic             o_start;
  logic             i_finish;
  logic             o_busy;
  logic             o_layer_done;
  logic             o_prog_done;
  logic [CNT_W-1:0] o_layer_cnt;
  logic             o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  layer_seq #(
    .DEPTH     (DEPTH),
    .TIMEOUT_W (TIMEOUT_W),
    .CNT_W     (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_mode    (i_cmd_mode),
    .i_cmd_relu_en (i_cmd_relu_en),
    .i_cmd_last    (i_cmd_last),
    .o_mode        (o_mode),
    .o_relu_en     (o_relu_en),
    .o_start       (o_start),
    .i_finish      (i_finish),
    .o_busy        (o_busy),
    .o_layer_done  (o_layer_done),
    .o_prog_done   (o_prog_done),
    .o_layer_cnt   (o_layer_cnt),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    i_rst_n = 1'b0;
    repeat (cycles) tick();
    i_rst_n = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".ready"},   32'(o_cmd_ready),  32'd1);
    chk({tag, ".start"},   32'(o_start),      32'd0);
    chk({tag, ".busy"},    32'(o_busy),       32'd0);
    chk({tag, ".done"},    32'(o_layer_done), 32'd0);
    chk({tag, ".prog"},    32'(o_prog_done),  32'd0);
    chk({tag, ".cnt"},     32'(o_layer_cnt),  32'd0);
    chk({tag, ".timeout"}, 32'(o_timeout),    32'd0);
    chk({tag, ".mode"},    32'(o_mode),       32'd0);
    chk({tag, ".relu"},    32'(o_relu_en),    32'd0);
  endtask

  task automatic drive_cmd(input logic v, input logic [1:0] m, input logic r, input logic l);
    i_cmd_valid   = v;
    i_cmd_mode    = m;
    i_cmd_relu_en = r;
    i_cmd_last    = l;
  endtask

  // Randomized-phase model: per accepted command, its accept / start / finish cycles.
  int         acc_c [N];
  int         st_c  [N];
  int         fin_c [N];
  int         dly   [N];
  int         pos   [N];
  logic [1:0] m_mode [N];
  logic       m_relu [N];
  logic       m_last [N];

  initial begin
    int   n_acc, c, occ, cur;
    bit   vld, done_all, exp_ready, exp_start, exp_done, exp_prog, exp_busy, in_run, fin_now;
    int   exp_cnt;

    i_rst_n  = 1'b0;
    i_finish = 1'b0;
    drive_cmd(1'b0, 2'd0, 1'b0, 1'b0);

    // Reset with finish pulses that must be ignored.
    i_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_finish = i[0];
      tick();
    end
    chk_idle_outputs("reset");
    i_rst_n  = 1'b1;
    i_finish = 1'b0;
    tick();
    chk_idle_outputs("post_reset");

    // Single layer: accept in cycle 0, start in cycle 2, finish in cycle 9, done in cycle 10.
    drive_cmd(1'b1, 2'd2, 1'b1, 1'b1);
    tick();
    drive_cmd(1'b0, 2'd0, 1'b0, 1'b0);
    chk("single.start_c1", 32'(o_start), 32'd0);
    tick();
    chk("single.start_c2", 32'(o_start), 32'd1);
    chk("single.mode", 32'(o_mode), 32'd2);
    chk("single.relu", 32'(o_relu_en), 32'd1);
    chk("single.busy_launch", 32'(o_busy), 32'd1);
    i_finish = 1'b1;
    tick();
    i_finish = 1'b0;
    chk("single.start_c3", 32'(o_start), 32'd0);
    chk("single.finish_in_launch_ignored", 32'(o_layer_done), 32'd0);
    chk("single.busy_run", 32'(o_busy), 32'd1);
    repeat (6) tick();
    i_finish = 1'b1;
    tick();
    i_finish = 1'b0;
    chk("single.done", 32'(o_layer_done), 32'd1);
    chk("single.prog", 32'(o_prog_done), 32'd1);
    chk("single.cnt", 32'(o_layer_cnt), 32'd1);
    chk("single.busy_after", 32'(o_busy), 32'd0);
    tick();
    chk("single.done_pulse", 32'(o_layer_done), 32'd0);
    chk("single.prog_pulse", 32'(o_prog_done), 32'd0);
    chk("single.cnt_hold", 32'(o_layer_cnt), 32'd1);
    chk("single.mode_hold", 32'(o_mode), 32'd2);

    // Back-pressure: push every cycle with no finish; five accepted, ready low from cycle 5.
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp.ready_c%0d", i), 32'(o_cmd_ready), 32'(i < 5));
      drive_cmd(1'b1, 2'(i), 1'b0, 1'b0);
      tick();
    end
    drive_cmd(1'b0, 2'd0, 1'b0, 1'b0);

    // Reset while running with commands queued: everything discarded.
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    chk_idle_outputs("mid_reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_reset.no_start", 32'(o_start), 32'd0);
      chk("mid_reset.no_busy", 32'(o_busy), 32'd0);
    end
    chk("mid_reset.ready", 32'(o_cmd_ready), 32'd1);

    // Watchdog: RUN cycles 3..18 without finish, ERR and timeout from cycle 19.
    do_reset(2);
    drive_cmd(1'b1, 2'd3, 1'b0, 1'b1);
    tick();
    drive_cmd(1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    chk("wd.start", 32'(o_start), 32'd1);
    repeat (16) tick();
    chk("wd.timeout_c18", 32'(o_timeout), 32'd0);
    chk("wd.busy_c18", 32'(o_busy), 32'd1);
    tick();
    chk("wd.timeout_c19", 32'(o_timeout), 32'd1);
    chk("wd.busy_c19", 32'(o_busy), 32'd0);
    chk("wd.ready_c19", 32'(o_cmd_ready), 32'd0);
    i_finish = 1'b1;
    drive_cmd(1'b1, 2'd1, 1'b1, 1'b0);
    tick();
    i_finish = 1'b0;
    drive_cmd(1'b0, 2'd0, 1'b0, 1'b0);
    chk("wd.no_done_c20", 32'(o_layer_done), 32'd0);
    tick();
    chk("wd.no_done_c21", 32'(o_layer_done), 32'd0);
    chk("wd.sticky", 32'(o_timeout), 32'd1);
    chk("wd.no_start", 32'(o_start), 32'd0);
    chk("wd.layer_cnt", 32'(o_layer_cnt), 32'd0);

    // Randomized program against the schedule model.
    for (int i = 0; i < N; i++) begin
      m_mode[i] = 2'($urandom_range(0, 3));
      m_relu[i] = 1'($urandom_range(0, 1));
      m_last[i] = (i == N - 1) || ($urandom_range(0, 2) == 0);
      dly[i]    = $urandom_range(1, 8);
    end
    do_reset(2);
    n_acc    = 0;
    c        = 0;
    vld      = 1'b0;
    done_all = 1'b0;
    while (!done_all && c < MAXC) begin
      occ = n_acc; exp_start = 0; exp_done = 0; exp_prog = 0; exp_busy = 0;
      in_run = 0; fin_now = 0; exp_cnt = 0; cur = -1;
      for (int i = 0; i < n_acc; i++) begin
        if (st_c[i] <= c) occ--;
        if (st_c[i] == c) exp_start = 1;
        if (st_c[i] <= c && c <= fin_c[i]) begin exp_busy = 1; cur = i; end
        if (st_c[i] < c && c <= fin_c[i]) in_run = 1;
        if (fin_c[i] == c) fin_now = 1;
        if (fin_c[i] + 1 == c) begin exp_done = 1; exp_prog = m_last[i]; exp_cnt = pos[i]; end
      end
      exp_ready = (occ < DEPTH);
      chk("rand.ready", 32'(o_cmd_ready), 32'(exp_ready));
      chk("rand.start", 32'(o_start), 32'(exp_start));
      chk("rand.busy", 32'(o_busy), 32'(exp_busy));
      chk("rand.done", 32'(o_layer_done), 32'(exp_done));
      chk("rand.prog", 32'(o_prog_done), 32'(exp_prog));
      if (exp_done) chk("rand.cnt", 32'(o_layer_cnt), 32'(exp_cnt));
      if (cur >= 0) begin
        chk("rand.mode", 32'(o_mode), 32'(m_mode[cur]));
        chk("rand.relu", 32'(o_relu_en), 32'(m_relu[cur]));
      end

      i_finish = fin_now || (!in_run && ($urandom_range(0, 3) == 0));
      if (!vld && n_acc < N) vld = ($urandom_range(0, 2) != 0);
      if (n_acc < N) drive_cmd(vld, m_mode[n_acc], m_relu[n_acc], m_last[n_acc]);
      else           drive_cmd(1'b0, 2'd0, 1'b0, 1'b0);
      if (vld && exp_ready && n_acc < N) begin
        acc_c[n_acc] = c;
        st_c[n_acc]  = c + 2;
        if (n_acc > 0 && fin_c[n_acc-1] + 2 > st_c[n_acc]) st_c[n_acc] = fin_c[n_acc-1] + 2;
        fin_c[n_acc] = st_c[n_acc] + dly[n_acc];
        pos[n_acc]   = (n_acc == 0 || m_last[n_acc-1]) ? 1 : pos[n_acc-1] + 1;
        n_acc++;
        vld = 1'b0;
      end
      tick();
      c++;
      if (n_acc == N && c > fin_c[N-1] + 3) done_all = 1'b1;
    end
    i_finish = 1'b0;
    drive_cmd(1'b0, 2'd0, 1'b0, 1'b0);
    chk("rand.completed_in_budget", 32'(done_all), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
